fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
- Sequential single-MAC FIR engine that sits directly in front of the single-port coefficient ROM.
- Drives the ROM address, consumes the ROM's registered output, and multiply-accumulates it against an internal circular sample delay line.
- Accepts one input sample per valid/ready handshake and returns one filtered output sample per valid/ready handshake.
- Time-multiplexes one multiplier over TAPS cycles per sample.

Parameters:
- DATA_WIDTH, 16, signed input sample width.
- COEF_WIDTH, 16, signed coefficient width; equals the ROM DATA_WIDTH.
- ADR_WIDTH, 8, ROM address width; TAPS must be <= 2**ADR_WIDTH.
- TAPS, 256, number of filter taps and delay-line depth (>=2; need not be a power of 2).
- ROM_LATENCY, 2, cycles from rom_adr to valid rom_q. Use 2 for the M10K variant and 1 for the RTL variant.
- OUT_WIDTH, 16, signed output width.
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  DATA_WIDTH  signed input sample
- rom_adr  out  ADR_WIDTH  coefficient ROM address (registered)
- rom_q  in  COEF_WIDTH  coefficient ROM data, ROM_LATENCY cycles after rom_adr
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- m_data  out  OUT_WIDTH  signed filtered sample (registered)

Behaviour:
- Reset values (applied asynchronously): state=INIT, s_ready=0, m_valid=0, m_data=0, rom_adr=0, accumulator=0, write pointer=0, pipeline valid shift register=0.
- Accumulator width: ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+ADR_WIDTH.
- INIT state: writes zero to delay-line entries 0..TAPS-1, one per cycle, over TAPS cycles with s_ready=0, then goes to IDLE.
- IDLE state: s_ready=1.
  - On s_valid&&s_ready (accept edge E0): write s_data to delay[wptr], clear the accumulator, set rom_adr=0, go to RUN.
  - wptr for the next sample = (wptr+1) mod TAPS.
- RUN state: in cycle 1+k (k=0..TAPS-1), rom_adr=k and the delay read index is (newest - k) mod TAPS, with explicit wrap for non-power-of-2 TAPS.
  - The sample read is delayed ROM_LATENCY cycles to align with rom_q.
  - A valid bit is shifted alongside; when it is set, acc += sample*rom_q (signed, full precision, sign-extended).
  - After k=TAPS-1 is issued, go to DRAIN. rom_adr holds TAPS-1.
- DRAIN state: wait until the valid shift register is empty.
  - Then m_data = sat(acc >>> OUT_SHIFT) to OUT_WIDTH, clamped to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1], truncation toward -inf.
  - m_valid=1, go to OUT.
  - m_valid first rises on edge E0+TAPS+ROM_LATENCY+1.
- OUT state: hold m_valid and m_data stable until m_valid&&m_ready, then m_valid=0 on that edge and go to IDLE (s_ready=1 the next cycle).
  - No sample is accepted while in RUN, DRAIN or OUT; s_valid is ignored there.
- Output mapping: tap k multiplies coefficient rom[k] by x[n-k]. y[n] = sum over k of rom[k]*x[n-k], where x[n] is the newest sample.
- Throughput: one sample per TAPS+ROM_LATENCY+3 cycles when m_ready=1.
- Reset mid-operation: any state returns to INIT. The in-flight result is discarded and the delay line is re-zeroed. m_valid drops immediately.

Test Plan:
- Impulse: TAPS=4, ROM=[1,2,3,4], OUT_SHIFT=0; feed 1,0,0,0,0 -> m_data 1,2,3,4,0. INIT takes 4 cycles before the first s_ready.
- Latency: ROM_LATENCY=1 and =2 with the same ROM and input -> identical outputs. m_valid rises exactly TAPS+ROM_LATENCY+1 edges after accept; rom_adr sequence is 0,1,2,3.
- Saturation: TAPS=4, ROM all 32767, samples 32767, OUT_SHIFT=0 -> m_data 32767 once full. Negative samples -32768 -> -32768. OUT_SHIFT=15 with ROM=[16384,0,0,0] and sample 1000 -> 500.
- Backpressure: hold m_ready=0 for 20 cycles -> m_valid and m_data stay stable, s_ready stays 0, and s_valid pulses are ignored with no sample lost from the accepted stream. Releasing m_ready -> single transfer, then s_ready=1.
- Wrap: TAPS=5 (non-power-of-2), feed 12 samples 1..12 with ROM=[1,1,1,1,1] -> outputs 1,3,6,10,15,20,25,...,50 (sum of the last 5).
- Reset mid-RUN: assert reset at k=2 -> m_valid=0 and s_ready=0 immediately, INIT runs again. The next impulse reproduces the impulse-test outputs with no residue from before reset.

Source files
------------

// File: rtl/fir_mac_seq_if.sv
// Handshake and coefficient-ROM bundle for the sequential FIR MAC engine.
// master = engine side, slave = sample source / sink / ROM side.
interface fir_mac_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ADR_WIDTH  = 8,
  parameter int OUT_WIDTH  = 16
);
  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic        [ADR_WIDTH-1:0]  rom_adr;
  logic signed [COEF_WIDTH-1:0] rom_q;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [OUT_WIDTH-1:0]  m_data;

  modport master (
    input  s_valid, s_data, rom_q, m_ready,
    output s_ready, rom_adr, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, rom_q, m_ready,
    input  s_ready, rom_adr, m_valid, m_data
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Single-multiplier FIR: walks the coefficient ROM once per accepted sample,
// MACs against a circular delay line and emits one saturated result.
module fir_mac_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int ADR_WIDTH   = 8,
  parameter int TAPS        = 256,
  parameter int ROM_LATENCY = 2,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SHIFT   = 15
) (
  input  logic             clk,
  input  logic             reset,
  fir_mac_seq_if.master    bus
);

  localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + ADR_WIDTH;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam int IDX_W      = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [ADR_WIDTH-1:0] LAST_K   = ADR_WIDTH'(TAPS - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_RUN, ST_DRAIN, ST_OUT
  } state_t;

  // Arithmetic shift floors toward -inf; the clamp then fits OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] sat_shift(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> OUT_SHIFT;
    if (s > SAT_MAX)      return OUT_MAX;
    else if (s < SAT_MIN) return OUT_MIN;
    else                  return s[OUT_WIDTH-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
    return (i == '0) ? LAST_IDX : i - IDX_W'(1);
  endfunction

  state_t                        state, state_nxt;
  logic [IDX_W-1:0]              wptr;
  logic [IDX_W-1:0]              rd_idx;
  logic [ADR_WIDTH-1:0]          k;
  logic [ADR_WIDTH-1:0]          rom_adr;
  logic                          m_valid;
  logic signed [OUT_WIDTH-1:0]   m_data;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [ROM_LATENCY-1:0]        vld_p;
  logic signed [DATA_WIDTH-1:0]  samp_p [ROM_LATENCY];
  logic signed [DATA_WIDTH-1:0]  dly [TAPS];
  logic                          wr_en;
  logic signed [DATA_WIDTH-1:0]  wr_data;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;

  assign bus.s_ready = (state == ST_IDLE);
  assign bus.rom_adr = rom_adr;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state)
      ST_INIT: begin
        wr_en = 1'b1;
        if (wptr == LAST_IDX) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.s_valid) begin
          wr_en     = 1'b1;
          wr_data   = bus.s_data;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:   if (k == LAST_K) state_nxt = ST_DRAIN;
      ST_DRAIN: if (vld_p == '0) state_nxt = ST_OUT;
      ST_OUT:   if (bus.m_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Delay line: INIT zero-fills through wptr, IDLE writes the accepted sample.
  always_ff @(posedge clk) begin
    if (wr_en) dly[wptr] <= wr_data;
  end

  // Stage p0..pN: sample read aligned to the ROM's registered output.
  always_ff @(posedge clk) begin
    samp_p[0] <= dly[rd_idx];
    for (int i = 1; i < ROM_LATENCY; i++) samp_p[i] <= samp_p[i-1];
  end

  assign prod     = samp_p[ROM_LATENCY-1] * bus.rom_q;
  assign prod_ext = ACC_WIDTH'(prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      wptr    <= '0;
      rd_idx  <= '0;
      k       <= '0;
      rom_adr <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      acc     <= '0;
      vld_p   <= '0;
    end else begin
      state    <= state_nxt;
      vld_p[0] <= (state == ST_RUN);
      for (int i = 1; i < ROM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      case (state)
        ST_INIT: wptr <= idx_inc(wptr);
        ST_IDLE: begin
          if (bus.s_valid) begin
            rd_idx  <= wptr;
            wptr    <= idx_inc(wptr);
            k       <= '0;
            rom_adr <= '0;
            acc     <= '0;
          end
        end
        ST_RUN: begin
          if (k != LAST_K) begin
            k       <= k + ADR_WIDTH'(1);
            rom_adr <= k + ADR_WIDTH'(1);
            rd_idx  <= idx_dec(rd_idx);
          end
        end
        ST_DRAIN: begin
          if (vld_p == '0) begin
            m_valid <= 1'b1;
            m_data  <= sat_shift(acc);
          end
        end
        ST_OUT:  if (bus.m_ready) m_valid <= 1'b0;
        default: ;
      endcase
      // MAC stage: accumulate once the aligned tap reaches the end of the pipe.
      if (vld_p[ROM_LATENCY-1]) acc <= acc + prod_ext;
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: four instances cover ROM latency 1/2,
// non-power-of-2 TAPS and a shifted output.
module tb_fir_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   rom0 [4];
  int   q0[$], q1[$], q2[$], q3[$];
  int   mon_e;

  logic               sv [4];
  logic signed [15:0] sd [4];
  logic               mr [4];
  logic               sr [4];
  logic               mv [4];
  logic signed [15:0] md [4];
  logic [7:0]         ra [4];
  logic signed [15:0] r0a, r2a, r3a;

  fir_mac_seq_if if0 ();
  fir_mac_seq_if if1 ();
  fir_mac_seq_if if2 ();
  fir_mac_seq_if if3 ();

  assign if0.s_valid = sv[0]; assign if0.s_data = sd[0]; assign if0.m_ready = mr[0];
  assign sr[0] = if0.s_ready; assign mv[0] = if0.m_valid; assign md[0] = if0.m_data; assign ra[0] = if0.rom_adr;
  assign if1.s_valid = sv[1]; assign if1.s_data = sd[1]; assign if1.m_ready = mr[1];
  assign sr[1] = if1.s_ready; assign mv[1] = if1.m_valid; assign md[1] = if1.m_data; assign ra[1] = if1.rom_adr;
  assign if2.s_valid = sv[2]; assign if2.s_data = sd[2]; assign if2.m_ready = mr[2];
  assign sr[2] = if2.s_ready; assign mv[2] = if2.m_valid; assign md[2] = if2.m_data; assign ra[2] = if2.rom_adr;
  assign if3.s_valid = sv[3]; assign if3.s_data = sd[3]; assign if3.m_ready = mr[3];
  assign sr[3] = if3.s_ready; assign mv[3] = if3.m_valid; assign md[3] = if3.m_data; assign ra[3] = if3.rom_adr;

  fir_mac_seq #(.TAPS(4), .ROM_LATENCY(2), .OUT_SHIFT(0))
    u0 (.clk(clk), .reset(reset), .bus(if0.master));
  fir_mac_seq #(.TAPS(4), .ROM_LATENCY(1), .OUT_SHIFT(0))
    u1 (.clk(clk), .reset(reset), .bus(if1.master));
  fir_mac_seq #(.TAPS(5), .ROM_LATENCY(2), .OUT_SHIFT(0))
    u2 (.clk(clk), .reset(reset), .bus(if2.master));
  fir_mac_seq #(.TAPS(4), .ROM_LATENCY(2), .OUT_SHIFT(15))
    u3 (.clk(clk), .reset(reset), .bus(if3.master));

  // Coefficient ROM models with the matching read latency.
  always @(posedge clk) begin
    r0a       <= 16'(rom0[ra[0][1:0]]);
    if0.rom_q <= r0a;
  end
  always @(posedge clk) if1.rom_q <= 16'(rom0[ra[1][1:0]]);
  always @(posedge clk) begin
    r2a       <= 16'sd1;
    if2.rom_q <= r2a;
  end
  always @(posedge clk) begin
    r3a       <= (ra[3] == 8'd0) ? 16'sd16384 : 16'sd0;
    if3.rom_q <= r3a;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int d, input int v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction

  function automatic bit pop(input int d, output int e);
    e = 0;
    case (d)
      0: if (q0.size() != 0) begin e = q0.pop_front(); return 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); return 1'b1; end
      2: if (q2.size() != 0) begin e = q2.pop_front(); return 1'b1; end
      default: if (q3.size() != 0) begin e = q3.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  function automatic int qsize();
    return q0.size() + q1.size() + q2.size() + q3.size();
  endfunction

  // Monitor: every output transfer pops and checks the next expected value.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (!reset && mv[d] && mr[d]) begin
        if (pop(d, mon_e)) chk($sformatf("out_u%0d", d), int'(md[d]), mon_e);
        else begin
          total++;
          bad++;
          $display("FAIL out_u%0d unexpected: got %0d, want none", d, md[d]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int v);
    int n = 0;
    while (!sr[d] && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("s_ready_u%0d", d), int'(sr[d]), 1);
    if (!sr[d]) return;
    sv[d] = 1'b1;
    sd[d] = 16'(v);
    tick();
    sv[d] = 1'b0;
  endtask

  task automatic send_chk(input int d, input int v, input int lat);
    int n;
    send(d, v);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rom_adr_u%0d_k%0d", d, k), int'(ra[d]), k);
      tick();
    end
    n = 4;
    while (!mv[d] && n < 60) begin
      tick();
      n++;
    end
    chk($sformatf("latency_u%0d", d), n, 4 + lat + 1);
  endtask

  task automatic init_count(output int c0, output int c2);
    c0 = 0;
    c2 = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (sr[0] && c0 == 0) c0 = n;
      if (sr[2] && c2 == 0) c2 = n;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qsize() != 0 || mv[0] || mv[1] || mv[2] || mv[3]) && n < 400) begin
      tick();
      n++;
    end
    chk(name, qsize(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c2, n;
    int imp_exp [5]   = '{1, 2, 3, 4, 0};
    int wrap_exp [12] = '{1, 3, 6, 10, 15, 20, 25, 30, 35, 40, 45, 50};
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
      mr[i] = 1'b1;
    end
    rom0 = '{1, 2, 3, 4};
    tick();
    tick();
    chk("rst_s_ready", int'(sr[0]), 0);
    chk("rst_m_valid", int'(mv[0]), 0);
    chk("rst_m_data", int'(md[0]), 0);
    chk("rst_rom_adr", int'(ra[0]), 0);
    reset = 1'b0;
    init_count(c0, c2);
    chk("init_cycles_t4", c0, 4);
    chk("init_cycles_t5", c2, 5);

    // Impulse through ROM latency 2 and 1 side by side
    for (int i = 0; i < 5; i++) begin
      push(0, imp_exp[i]);
      push(1, imp_exp[i]);
    end
    fork
      begin send_chk(0, 1, 2); repeat (4) send(0, 0); end
      begin send_chk(1, 1, 1); repeat (4) send(1, 0); end
    join
    drain("drain_impulse");

    // Saturation at both rails
    rom0 = '{32767, 32767, 32767, 32767};
    repeat (4) push(0, 32767);
    push(0, 32767); push(0, -32768); push(0, -32768); push(0, -32768);
    repeat (4) send(0, 32767);
    repeat (4) send(0, -32768);
    drain("drain_sat");

    // Shift by 15 with floor rounding
    push(3, 500); push(3, -1); push(3, 1);
    send(3, 1000); send(3, -1); send(3, 3);
    drain("drain_shift");

    // Backpressure
    rom0 = '{1, 2, 3, 4};
    push(0, -32768); push(0, -32768); push(0, -32768); push(0, 0);
    repeat (4) send(0, 0);
    drain("drain_flush");
    mr[0] = 1'b0;
    push(0, 7);
    send(0, 7);
    n = 0;
    while (!mv[0] && n < 60) begin
      tick();
      n++;
    end
    chk("bp_m_valid_rise", int'(mv[0]), 1);
    for (int i = 0; i < 20; i++) begin
      sv[0] = (i % 3 == 0);
      sd[0] = 16'sd999;
      tick();
      chk("bp_m_valid_hold", int'(mv[0]), 1);
      chk("bp_m_data_hold", int'(md[0]), 7);
      chk("bp_s_ready_low", int'(sr[0]), 0);
    end
    sv[0] = 1'b0;
    mr[0] = 1'b1;
    tick();
    chk("bp_release_m_valid", int'(mv[0]), 0);
    chk("bp_release_s_ready", int'(sr[0]), 1);
    push(0, 16);
    send(0, 2);
    drain("drain_bp");

    // Non-power-of-2 wrap
    for (int i = 0; i < 12; i++) push(2, wrap_exp[i]);
    for (int i = 1; i <= 12; i++) send(2, i);
    drain("drain_wrap");

    // Reset in the middle of RUN
    send(0, 9);
    tick();
    tick();
    chk("mid_run_k2", int'(ra[0]), 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", int'(mv[0]), 0);
    chk("mid_rst_s_ready", int'(sr[0]), 0);
    tick();
    reset = 1'b0;
    init_count(c0, c2);
    chk("reinit_cycles_t4", c0, 4);
    for (int i = 0; i < 5; i++) push(0, imp_exp[i]);
    send(0, 1);
    repeat (4) send(0, 0);
    drain("drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
